// File: rtl/dense_acc_relu.sv
// Dense-layer neuron tail: bias-seeded accumulation of N_IN unsigned
// products, arithmetic shift to output scale, ReLU with upper saturation.
// Ports:
//   ap_clk, ap_rst_n           clock, async active-low reset
//   in_data/in_valid/in_ready  product stream, in_last marks vector end
//   bias                       signed bias, taken on first beat of a vector
//   out_data/out_valid/out_ready  one result per vector
//   err                        sticky in_last framing error
module dense_acc_relu #(
  parameter int PROD_W = 24,
  parameter int N_IN   = 16,
  parameter int BIAS_W = 16,
  parameter int ACC_W  = 32,
  parameter int SHIFT  = 10,
  parameter int OUT_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [BIAS_W-1:0] bias,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);

  localparam int CNT_W = $clog2(N_IN);

  typedef enum logic [1:0] {
    S_ACC,
    S_FIN,
    S_OUT
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     err_q, err_d;

  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  s;
  logic                     beat;
  logic                     last_cnt;

  // Gated by reset so nothing is offered as accepted while held in reset.
  assign in_ready  = ap_rst_n & (state_q == S_ACC);
  assign beat      = in_valid & in_ready;
  assign last_cnt  = (cnt_q == CNT_W'(N_IN - 1));
  assign bias_ext  = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
  assign prod_ext  = {{(ACC_W-PROD_W){1'b0}}, in_data};

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    s           = acc_q >>> SHIFT;
    unique case (state_q)
      S_ACC: begin
        if (beat) begin
          if (cnt_q == '0) begin
            acc_d = bias_ext + prod_ext;
          end else begin
            acc_d = acc_q + prod_ext;
          end
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (in_last != last_cnt) begin
            err_d = 1'b1;
          end
        end
      end
      S_FIN: begin
        out_valid_d = 1'b1;
        state_d     = S_OUT;
        if (s[ACC_W-1]) begin
          out_data_d = '0;
        end else if (|s[ACC_W-1:OUT_W]) begin
          out_data_d = '1;
        end else begin
          out_data_d = s[OUT_W-1:0];
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_ACC;
        end
      end
      default: begin
        state_d = S_ACC;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_dense_acc_relu.sv
// Directed bench for dense_acc_relu.
// Hand-computed expectations per scenario.
module tb_dense_acc_relu;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [15:0] bias;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  int checks;
  int failures;

  dense_acc_relu dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .bias      (bias),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Present one beat after `gap` idle cycles; returns 1 ns after the
  // accepting edge with in_valid dropped.
  task automatic beat(input logic [23:0] d, input logic [15:0] b,
                      input logic l, input int gap);
    int n;
    for (int i = 0; i < gap; i++) @(negedge ap_clk);
    @(negedge ap_clk);
    in_data  = d;
    bias     = b;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic vec(input logic [23:0] d, input logic [15:0] b);
    for (int i = 0; i < 16; i++) beat(d, b, (i == 15), 0);
  endtask

  // Wait (bounded) for a result, check it, then complete the handshake.
  task automatic get_out(input logic [15:0] exp, input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid got=%0b required=1", nm, out_valid);
    end
    checks++;
    if (out_data !== exp) begin
      failures++;
      $display("FAIL %s_data got=%0d required=%0d", nm, out_data, exp);
    end
    @(negedge ap_clk);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drop got=%0b required=0", nm, out_valid);
    end
  endtask

  task automatic test_reset();
    ap_rst_n  = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    bias      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0 ||
        err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%0b ov=%0b od=%0d err=%0b required 0 0 0 0",
               in_ready, out_valid, out_data, err);
    end
    ap_rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_rdy got=%0b required=1", in_ready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) beat(24'd1024, 16'd0, (i == 15), 0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_fin got ov=%0b rdy=%0b required 0 0",
               out_valid, in_ready);
    end
    @(posedge ap_clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd16) begin
      failures++;
      $display("FAIL basic_latency got ov=%0b od=%0d required 1 16",
               out_valid, out_data);
    end
    get_out(16'd16, "basic");
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL basic_err got=%0b required=0", err);
    end
  endtask

  task automatic test_relu();
    vec(24'd1000, 16'hB1E0);
    get_out(16'd0, "relu_neg");
    vec(24'd0, 16'd1023);
    get_out(16'd0, "relu_1023");
    vec(24'd0, 16'd1024);
    get_out(16'd1, "relu_1024");
  endtask

  task automatic test_saturation();
    vec(24'hFFFFFF, 16'd0);
    get_out(16'd65535, "sat");
  endtask

  task automatic test_backpressure();
    int bad;
    vec(24'd1024, 16'd0);
    @(posedge ap_clk);
    #1;
    bad = 0;
    in_data  = 24'hFFFFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      if (out_valid !== 1'b1 || out_data !== 16'd16 || in_ready !== 1'b0)
        bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got od=%0d rdy=%0b bad=%0d required 16 0 0",
               out_data, in_ready, bad);
    end
    get_out(16'd16, "bp_release");
    vec(24'd2048, 16'd0);
    get_out(16'd32, "bp_next");
  endtask

  task automatic test_framing();
    // 1000*(1+..+16) + 500 = 136500 -> >>10 = 133
    for (int i = 0; i < 16; i++) begin
      beat(24'(1000 * (i + 1)), 16'd500, (i == 2), (i % 3));
      if (i == 1) begin
        checks++;
        if (err !== 1'b0) begin
          failures++;
          $display("FAIL frame_pre got=%0b required=0", err);
        end
      end
      if (i == 2) begin
        checks++;
        if (err !== 1'b1) begin
          failures++;
          $display("FAIL frame_err got=%0b required=1", err);
        end
      end
    end
    get_out(16'd133, "frame");
    repeat (3) @(negedge ap_clk);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL frame_sticky got=%0b required=1", err);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) beat(24'd5000, 16'd0, 1'b0, 0);
    @(negedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async got ov=%0b err=%0b rdy=%0b required 0 0 0",
               out_valid, err, in_ready);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    vec(24'd2048, 16'd0);
    get_out(16'd32, "midrst_next");
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL midrst_err got=%0b required=0", err);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_backpressure();
    test_framing();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
